// File: rtl/niosii_ram_master_pkg.sv
// niosii_ram_master shared definitions.
// RAM geometry, FSM states and bus constants.
package niosii_ram_master_pkg;

   localparam int DEPTH      = 6400;
   localparam int ADDR_W     = 13;
   localparam int FIFO_DEPTH = 3;

   localparam logic [3:0] BE_ALL = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN
   } state_t;

endpackage

// File: rtl/niosii_ram_master_if.sv
// Command, stream and Avalon-MM signal bundle.
// master = block mover side, slave = fabric/RAM side.
interface niosii_ram_master_if;
   import niosii_ram_master_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W:0]   cmd_len;

   logic [31:0]       wr_data;
   logic              wr_valid;
   logic              wr_ready;

   logic [31:0]       rd_data;
   logic              rd_valid;
   logic              rd_ready;

   logic              busy;
   logic              done;
   logic              err;

   logic [ADDR_W-1:0] m_address;
   logic [3:0]        m_byteenable;
   logic              m_chipselect;
   logic              m_write;
   logic [31:0]       m_writedata;
   logic              m_clken;
   logic [31:0]       m_readdata;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len,
      input  wr_data, wr_valid, rd_ready, m_readdata,
      output cmd_ready, wr_ready, rd_data, rd_valid,
      output busy, done, err,
      output m_address, m_byteenable, m_chipselect,
      output m_write, m_writedata, m_clken
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_len,
      output wr_data, wr_valid, rd_ready, m_readdata,
      input  cmd_ready, wr_ready, rd_data, rd_valid,
      input  busy, done, err,
      input  m_address, m_byteenable, m_chipselect,
      input  m_write, m_writedata, m_clken
   );

endinterface

// File: rtl/niosii_ram_master_fifo.sv
// Read-return buffer: small circular FIFO with count.
// Push and pop may coincide; reset flushes all entries.
module niosii_ram_master_fifo #(
   parameter int P_DEPTH = 3,
   parameter int P_WIDTH = 32,
   parameter int P_CNT_W = $clog2(P_DEPTH + 1)
) (
   input  logic               i_clk,
   input  logic               i_flush,
   input  logic               i_push,
   input  logic [P_WIDTH-1:0] i_data,
   input  logic               i_pop,
   output logic [P_WIDTH-1:0] o_data,
   output logic [P_CNT_W-1:0] o_count,
   output logic               o_empty
);

   localparam int PTR_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

   logic [P_WIDTH-1:0] r_mem [P_DEPTH];
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [P_CNT_W-1:0] r_count;

   function automatic logic [PTR_W-1:0] f_inc(
      input logic [PTR_W-1:0] p
   );
      if (p == PTR_W'(P_DEPTH - 1))
         return '0;
      return p + PTR_W'(1);
   endfunction

   // entry storage, no reset needed
   always_ff @(posedge i_clk) begin
      if (i_push)
         r_mem[r_wptr] <= i_data;
   end

   // pointers and occupancy
   always_ff @(posedge i_clk) begin
      if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push)
            r_wptr <= f_inc(r_wptr);
         if (i_pop)
            r_rptr <= f_inc(r_rptr);
         if (i_push && !i_pop)
            r_count <= r_count + P_CNT_W'(1);
         else if (!i_push && i_pop)
            r_count <= r_count - P_CNT_W'(1);
      end
   end

   assign o_data  = r_mem[r_rptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/niosii_ram_master.sv
// Block mover between streams and the on-chip RAM.
// Range-checks commands, then streams words in or out.
module niosii_ram_master
   import niosii_ram_master_pkg::*;
#(
   parameter int P_DEPTH      = DEPTH,
   parameter int P_FIFO_DEPTH = FIFO_DEPTH
) (
   input  logic                i_clk,
   input  logic                i_reset,
   niosii_ram_master_if.master bus
);

   localparam int CNT_W = $clog2(P_FIFO_DEPTH + 1);
   localparam logic [ADDR_W:0] END_MAX =
      (ADDR_W + 1)'(P_DEPTH);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [ADDR_W:0]   r_rem;
   logic [ADDR_W:0]   w_rem_nxt;
   logic              r_inflight;
   logic              r_done;
   logic              r_err;
   logic              w_done_nxt;
   logic              w_err_nxt;

   logic [ADDR_W:0]   w_end;
   logic              w_cmd_hs;
   logic              w_wr_hs;
   logic              w_issue;
   logic              w_pop;
   logic              w_last;
   logic [CNT_W:0]    w_occ;
   logic [CNT_W-1:0]  w_count;
   logic              w_empty;
   logic [31:0]       w_head;

   assign w_end    = {1'b0, bus.cmd_addr} + bus.cmd_len;
   assign w_cmd_hs = bus.cmd_valid && (r_state == IDLE);
   assign w_wr_hs  = bus.wr_valid && (r_state == WRITE);
   assign w_occ    = (CNT_W + 1)'(w_count)
                   + (CNT_W + 1)'(r_inflight);
   assign w_issue  = (r_state == READ)
                   && (w_occ < (CNT_W + 1)'(P_FIFO_DEPTH));
   assign w_pop    = !w_empty && bus.rd_ready;
   assign w_last   = (r_rem == (ADDR_W + 1)'(1));

   // next state, counters and completion pulses
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_rem_nxt   = r_rem;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_cmd_hs) begin
               if (w_end > END_MAX) begin
                  w_done_nxt = 1'b1;
                  w_err_nxt  = 1'b1;
               end else if (bus.cmd_len == '0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_addr_nxt  = bus.cmd_addr;
                  w_rem_nxt   = bus.cmd_len;
                  w_state_nxt = bus.cmd_write ? WRITE : READ;
               end
            end
         end
         WRITE: begin
            if (w_wr_hs) begin
               w_addr_nxt = r_addr + ADDR_W'(1);
               w_rem_nxt  = r_rem - (ADDR_W + 1)'(1);
               if (w_last) begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         READ: begin
            if (w_issue) begin
               w_addr_nxt = r_addr + ADDR_W'(1);
               w_rem_nxt  = r_rem - (ADDR_W + 1)'(1);
               if (w_last)
                  w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (!r_inflight && (w_empty ||
                (w_count == CNT_W'(1) && w_pop))) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // registered state; reset aborts any command silently
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_rem      <= '0;
         r_inflight <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_addr     <= w_addr_nxt;
         r_rem      <= w_rem_nxt;
         r_inflight <= w_issue;
         r_done     <= w_done_nxt;
         r_err      <= w_err_nxt;
      end
   end

   niosii_ram_master_fifo #(
      .P_DEPTH (P_FIFO_DEPTH),
      .P_WIDTH (32),
      .P_CNT_W (CNT_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_flush (i_reset),
      .i_push  (r_inflight),
      .i_data  (bus.m_readdata),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   assign bus.cmd_ready    = (r_state == IDLE);
   assign bus.wr_ready     = (r_state == WRITE);
   assign bus.rd_valid     = !w_empty;
   assign bus.rd_data      = w_head;
   assign bus.busy         = (r_state != IDLE);
   assign bus.done         = r_done;
   assign bus.err          = r_err;
   assign bus.m_address    = r_addr;
   assign bus.m_byteenable = BE_ALL;
   assign bus.m_chipselect = w_wr_hs || w_issue;
   assign bus.m_write      = w_wr_hs;
   assign bus.m_writedata  = bus.wr_data;
   assign bus.m_clken      = 1'b1;

endmodule

// File: tb/tb_niosii_ram_master.sv
// Scoreboard bench for niosii_ram_master.
// Drivers queue expected beats; a monitor checks them.
`timescale 1ns/1ps
module tb_niosii_ram_master;
   import niosii_ram_master_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   niosii_ram_master_if bus();

   niosii_ram_master dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   typedef struct { int a; logic [31:0] d; int c; } wr_exp_t;
   typedef struct { logic [31:0] d; int c; } rd_exp_t;
   typedef struct { logic e; int c; } dn_exp_t;

   wr_exp_t q_wr[$];
   rd_exp_t q_rd[$];
   dn_exp_t q_dn[$];
   wr_exp_t we;
   rd_exp_t re;
   dn_exp_t de;

   logic [31:0] ram [DEPTH];
   logic [31:0] shadow [int];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n_issue = 0;
   int n_pop = 0;

   task automatic chk(input string nm,
                      input longint act,
                      input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: one-cycle read latency
   always @(posedge clk) begin
      if (bus.m_chipselect && bus.m_address < DEPTH) begin
         if (bus.m_write)
            ram[bus.m_address] <= bus.m_writedata;
         bus.m_readdata <= ram[bus.m_address];
      end
   end

   // monitor: pops expectations on DUT events
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.m_chipselect)
            chk("addr_range", bus.m_address < DEPTH, 1);
         if (bus.m_chipselect && bus.m_write) begin
            chk("wr_expected", q_wr.size() > 0, 1);
            if (q_wr.size() > 0) begin
               we = q_wr.pop_front();
               chk("wr_addr", bus.m_address, we.a);
               chk("wr_data", bus.m_writedata, we.d);
               chk("wr_cycle", cyc, we.c);
            end
         end
         if (bus.m_chipselect && !bus.m_write)
            n_issue++;
         if (bus.rd_valid && bus.rd_ready) begin
            n_pop++;
            chk("rd_expected", q_rd.size() > 0, 1);
            if (q_rd.size() > 0) begin
               re = q_rd.pop_front();
               chk("rd_data", bus.rd_data, re.d);
               if (re.c >= 0)
                  chk("rd_cycle", cyc, re.c);
            end
         end
         chk("outstanding", n_issue - n_pop <= FIFO_DEPTH, 1);
         chk("err_w_done", bus.err & ~bus.done, 0);
         if (bus.done) begin
            chk("done_expected", q_dn.size() > 0, 1);
            chk("busy_at_done", bus.busy, 0);
            if (q_dn.size() > 0) begin
               de = q_dn.pop_front();
               chk("done_err", bus.err, de.e);
               if (de.c >= 0)
                  chk("done_cycle", cyc, de.c);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input bit wr, input int addr,
                           input int len, output int t);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = ADDR_W'(addr);
      bus.cmd_len   = (ADDR_W + 1)'(len);
      t = -1;
      for (int i = 0; i < 50 && t < 0; i++) begin
         @(negedge clk);
         if (bus.cmd_ready)
            t = cyc;
         tick();
      end
      bus.cmd_valid = 1'b0;
      chk("cmd_accept", t >= 0, 1);
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (q_wr.size() + q_rd.size() + q_dn.size() != 0
             && i < 300) begin
         tick();
         i++;
      end
      chk("idle_reached", i < 300, 1);
      tick();
      tick();
   endtask

   task automatic do_write(input int addr, input int n,
                           input logic [31:0] base);
      int t;
      int k;
      bit acc;
      bus.wr_valid = 1'b1;
      bus.wr_data  = base;
      send_cmd(1'b1, addr, n, t);
      for (int i = 0; i < n; i++) begin
         q_wr.push_back('{addr + i, base + 32'(i), t + 1 + i});
         shadow[addr + i] = base + 32'(i);
      end
      q_dn.push_back('{1'b0, t + n + 1});
      k = 0;
      for (int i = 0; i < n + 20 && k < n; i++) begin
         @(negedge clk);
         acc = bus.wr_ready && bus.wr_valid;
         tick();
         if (acc) begin
            k++;
            bus.wr_data = base + 32'(k);
         end
      end
      bus.wr_valid = 1'b0;
      wait_idle();
   endtask

   task automatic issue_read(input int addr, input int n,
                             input bit timed, output int t);
      logic [31:0] v;
      send_cmd(1'b0, addr, n, t);
      for (int i = 0; i < n; i++) begin
         v = shadow.exists(addr + i) ? shadow[addr + i] : 32'h0;
         q_rd.push_back('{v, timed ? t + 3 + i : -1});
      end
      q_dn.push_back('{1'b0, timed ? t + n + 3 : -1});
   endtask

   task automatic do_read(input int addr, input int n,
                          input bit tog);
      int t;
      bit [3:0] pat;
      pat = 4'b1001;
      bus.rd_ready = 1'b1;
      issue_read(addr, n, !tog, t);
      if (tog) begin
         for (int i = 0; i < 200 && q_rd.size() > 0; i++) begin
            bus.rd_ready = pat[i % 4];
            @(negedge clk);
            tick();
         end
         bus.rd_ready = 1'b1;
      end
      wait_idle();
   endtask

   task automatic do_reject(input int addr, input int len,
                            input bit e);
      int t;
      send_cmd(1'b1, addr, len, t);
      q_dn.push_back('{e, t + 1});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rej_no_cs", bus.m_chipselect, 0);
         chk("rej_ready", bus.cmd_ready, 1);
         tick();
      end
      wait_idle();
   endtask

   task automatic reset_mid_read();
      int t;
      int n0;
      bus.rd_ready = 1'b1;
      n0 = n_pop;
      issue_read(16, 8, 1'b1, t);
      for (int i = 0; i < 50 && n_pop - n0 < 2; i++) begin
         @(negedge clk);
         tick();
      end
      chk("two_beats", n_pop - n0, 2);
      reset = 1'b1;
      bus.rd_ready = 1'b0;
      q_rd.delete();
      q_dn.delete();
      n_issue = 0;
      n_pop = 0;
      tick();
      reset = 1'b0;
      bus.rd_ready = 1'b1;
      @(negedge clk);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      tick();
      for (int i = 0; i < 10; i++)
         tick();
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.wr_data   = '0;
      bus.wr_valid  = 1'b0;
      bus.rd_ready  = 1'b1;
      for (int i = 0; i < DEPTH; i++)
         ram[i] = 32'h0;
      tick();
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy0", bus.busy, 0);
      chk("rst_done0", bus.done, 0);
      chk("rst_err0", bus.err, 0);
      chk("rst_cs0", bus.m_chipselect, 0);
      chk("rst_wr0", bus.m_write, 0);
      chk("rst_rdv0", bus.rd_valid, 0);
      chk("rst_addr0", bus.m_address, 0);
      chk("rst_ready0", bus.cmd_ready, 1);
      chk("byteenable", bus.m_byteenable, 15);
      chk("clken", bus.m_clken, 1);
      tick();

      do_write(16, 4, 32'hA0);
      do_read(16, 4, 1'b0);
      do_read(16, 4, 1'b1);
      do_reject(6398, 3, 1'b1);
      do_reject(32, 0, 1'b0);
      do_write(6399, 1, 32'hDEADBEEF);
      do_read(6399, 1, 1'b0);
      do_read(0, 1, 1'b0);
      reset_mid_read();
      do_read(16, 2, 1'b0);

      chk("q_wr_empty", q_wr.size(), 0);
      chk("q_rd_empty", q_rd.size(), 0);
      chk("q_dn_empty", q_dn.size(), 0);
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
